// File: rtl/alu_sequencer_if.sv
// Bus between the host/ALU environment and alu_sequencer: instruction handshake,
// host load port, ALU operand/result path, status and debug read.
interface alu_sequencer_if #(
    parameter int n = 32
);
    logic         instr_valid;
    logic         instr_ready;
    logic [11:0]  instr;
    logic         load_en;
    logic [2:0]   load_addr;
    logic [n-1:0] load_data;
    logic [n-1:0] alu_a;
    logic [n-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [n-1:0] alu_result;
    logic [n-1:0] result;
    logic         done;
    logic         err;
    logic         busy;
    logic [2:0]   dbg_addr;
    logic [n-1:0] dbg_data;

    modport master (
        output instr_valid, instr, load_en, load_addr, load_data, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, result, done, err, busy, dbg_data
    );

    modport slave (
        input  instr_valid, instr, load_en, load_addr, load_data, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, result, done, err, busy, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state issue controller (IDLE/OPER/EXEC/WB) owning an 8 x n register file
// and driving a combinational ALU through registered operands and opcode.
module alu_sequencer #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    state_t       state_reg, state_next;
    logic [11:0]  instr_reg;
    logic [n-1:0] alu_a_reg, alu_b_reg, result_reg;
    logic [2:0]   alu_op_reg;
    logic [n-1:0] rf_reg [8];
    logic [7:0]   load_we, wb_we;
    logic         load_hit, wb_hit;
    logic         ready, done, err;
    logic [2:0]   op, rd, rs, rt;

    assign op = instr_reg[11:9];
    assign rd = instr_reg[8:6];
    assign rs = instr_reg[5:3];
    assign rt = instr_reg[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.instr_valid) state_next = OPER;
            OPER:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_reg == IDLE);
        done  = (state_reg == WB);
        err   = (state_reg == WB) && (op == OP_ILLEGAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg  <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.instr_valid) instr_reg <= bus.instr;
                OPER: begin
                    alu_a_reg  <= rf_reg[rs];
                    alu_b_reg  <= rf_reg[rt];
                    alu_op_reg <= op;
                end
                // An illegal op must leave the last written-back value visible.
                EXEC: if (op != OP_ILLEGAL) result_reg <= bus.alu_result;
                default: ;
            endcase
        end
    end

    // Loads only land in IDLE, so they can never collide with a WB write.
    assign load_hit = bus.load_en && (state_reg == IDLE);
    assign wb_hit   = (state_reg == WB) && (op != OP_ILLEGAL);

    for (genvar gi = 0; gi < 8; gi++) begin : g_we
        assign load_we[gi] = load_hit && (bus.load_addr == 3'(gi));
        assign wb_we[gi]   = wb_hit && (rd == 3'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load_we[i])    rf_reg[i] <= bus.load_data;
                else if (wb_we[i]) rf_reg[i] <= result_reg;
            end
        end
    end

    assign bus.instr_ready = ready;
    assign bus.busy        = !ready;
    assign bus.done        = done;
    assign bus.err         = err;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_op      = alu_op_reg;
    assign bus.result      = result_reg;
    assign bus.dbg_data    = rf_reg[bus.dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus randomized instructions,
// checked against a register-file/result model kept at instruction level.
module tb_alu_sequencer;
    localparam int n = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.n(n)) bus ();
    alu_sequencer #(.n(n)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    logic [31:0] model_rf [8];
    logic [31:0] model_result;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a;
            3'b001:  return ~a;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a | b;
            3'b101:  return a & b;
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Combinational ALU standing in for the lab-4 datapath
    always_comb bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [31:0] data);
        bus.dbg_addr = addr;
        #1;
        data = bus.dbg_data;
    endtask

    task automatic sweep(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            check($sformatf("%s_r%0d", tag, i), d, model_rf[i]);
        end
        @(negedge clk);
    endtask

    task automatic host_load(input logic [2:0] addr, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        @(negedge clk);
        bus.load_en = 1'b0;
        model_rf[addr] = data;
    endtask

    // mode 0: plain, 1: load alongside accept, 2: load attempted during EXEC
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] rt, input int mode, input logic [2:0] la,
                             input logic [31:0] ld);
        logic [31:0] exp_a, exp_b, exp_r;
        int t;
        t = 0;
        while (!bus.instr_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("ready_before_accept", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = {op, rd, rs, rt};
        if (mode == 1) begin
            bus.load_en   = 1'b1;
            bus.load_addr = la;
            bus.load_data = ld;
            model_rf[la]  = ld;
        end
        exp_a = model_rf[rs];
        exp_b = model_rf[rt];
        exp_r = (op == 3'b111) ? model_result : alu_ref(op, exp_a, exp_b);
        @(negedge clk);  // accept edge T behind us
        bus.instr_valid = 1'b0;
        bus.load_en     = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("ready_low_oper", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);  // T+1
        check("alu_a", bus.alu_a, exp_a);
        check("alu_b", bus.alu_b, exp_b);
        check("alu_op", 32'(bus.alu_op), 32'(op));
        check("done_early", 32'(bus.done), 32'd0);
        if (mode == 2) begin
            bus.load_en   = 1'b1;
            bus.load_addr = la;
            bus.load_data = ld;
        end
        @(negedge clk);  // T+2
        bus.load_en = 1'b0;
        check("done_wb", 32'(bus.done), 32'd1);
        check("err_wb", 32'(bus.err), (op == 3'b111) ? 32'd1 : 32'd0);
        check("result", bus.result, exp_r);
        @(negedge clk);  // T+3
        check("done_cleared", 32'(bus.done), 32'd0);
        check("err_cleared", 32'(bus.err), 32'd0);
        check("ready_back", 32'(bus.instr_ready), 32'd1);
        if (op != 3'b111) model_rf[rd] = exp_r;
        model_result = exp_r;
        txn++;
        $display("txn %0d op=%0d rd=%0d rs=%0d rt=%0d mode=%0d a=%h b=%h result=%h",
                 txn, op, rd, rs, rt, mode, exp_a, exp_b, bus.result);
        sweep("rf");
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_result = '0;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.dbg_addr    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_dbg", bus.dbg_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD r1 = r2 + r3
        host_load(3'd2, 32'd5);
        host_load(3'd3, 32'd7);
        run_instr(3'b010, 3'd1, 3'd2, 3'd3, 0, 3'd0, 32'd0);
        read_reg(3'd1, d);
        check("add_r1", d, 32'd12);

        // SUB and signed SLT
        run_instr(3'b011, 3'd0, 3'd2, 3'd3, 0, 3'd0, 32'd0);
        read_reg(3'd0, d);
        check("sub_r0", d, 32'hFFFF_FFFE);
        host_load(3'd2, 32'hFFFF_FFFF);
        host_load(3'd3, 32'd1);
        run_instr(3'b110, 3'd4, 3'd2, 3'd3, 0, 3'd0, 32'd0);
        read_reg(3'd4, d);
        check("slt_neg_lt_one", d, 32'd1);
        run_instr(3'b110, 3'd4, 3'd3, 3'd2, 0, 3'd0, 32'd0);
        read_reg(3'd4, d);
        check("slt_swapped", d, 32'd0);

        // NOT with rd == rs
        host_load(3'd4, 32'd0);
        host_load(3'd7, 32'hA5A5_A5A5);
        run_instr(3'b001, 3'd4, 3'd4, 3'd7, 0, 3'd0, 32'd0);
        read_reg(3'd4, d);
        check("not_r4", d, 32'hFFFF_FFFF);
        read_reg(3'd7, d);
        check("not_r7_kept", d, 32'hA5A5_A5A5);

        // Illegal opcode
        host_load(3'd5, 32'h0000_1234);
        run_instr(3'b111, 3'd5, 3'd1, 3'd2, 0, 3'd0, 32'd0);
        read_reg(3'd5, d);
        check("illegal_r5_kept", d, 32'h0000_1234);
        check("illegal_result_kept", bus.result, 32'hFFFF_FFFF);

        // Load during EXEC is dropped; load alongside accept is seen by OPER
        host_load(3'd6, 32'h66);
        run_instr(3'b000, 3'd0, 3'd1, 3'd1, 2, 3'd6, 32'h77);
        read_reg(3'd6, d);
        check("load_exec_ignored", d, 32'h66);
        host_load(3'd2, 32'd1);
        run_instr(3'b010, 3'd3, 3'd2, 3'd2, 1, 3'd2, 32'h10);
        read_reg(3'd3, d);
        check("load_same_cycle", d, 32'h20);

        // instr_valid held across two instructions: accepts 4 cycles apart
        host_load(3'd2, 32'd3);
        host_load(3'd3, 32'd4);
        bus.instr_valid = 1'b1;
        bus.instr = {3'b010, 3'd1, 3'd2, 3'd3};
        @(negedge clk);
        bus.instr = {3'b011, 3'd6, 3'd2, 3'd3};
        check("b2b_busy_t0", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("b2b_ready_t1", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        check("b2b_done_t2", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("b2b_ready_t3", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        check("b2b_second_accept", 32'(bus.busy), 32'd1);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_rf[1] = 32'd7;
        model_rf[6] = 32'hFFFF_FFFF;
        model_result = 32'hFFFF_FFFF;
        $display("txn b2b add r1 then sub r6 result=%h", bus.result);
        check("b2b_result", bus.result, 32'hFFFF_FFFF);
        sweep("b2b");

        // Randomized instructions and loads
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                host_load(3'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)));
            run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                      3'($urandom_range(0, 7)), $urandom);
        end

        // Asynchronous reset during EXEC
        host_load(3'd1, 32'h0);
        host_load(3'd2, 32'd9);
        host_load(3'd3, 32'd11);
        bus.instr_valid = 1'b1;
        bus.instr = {3'b010, 3'd1, 3'd2, 3'd3};
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        bus.dbg_addr = 3'd1;
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.instr_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_alu_a", bus.alu_a, 32'd0);
        check("arst_alu_b", bus.alu_b, 32'd0);
        check("arst_alu_op", 32'(bus.alu_op), 32'd0);
        check("arst_dbg_r1", bus.dbg_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        $display("txn reset during EXEC");
        repeat (2) @(negedge clk);
        check("arst_no_wb_done", 32'(bus.done), 32'd0);
        sweep("arst");
        host_load(3'd2, 32'd20);
        host_load(3'd3, 32'd22);
        run_instr(3'b010, 3'd1, 3'd2, 3'd3, 0, 3'd0, 32'd0);
        read_reg(3'd1, d);
        check("post_rst_add", d, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the lab-4 datapath: accepts 12-bit register-to-register instructions, reads two operands from an internal 8-entry register file, drives the combinational ALU's operand and opcode inputs, captures the ALU result and writes it back to the destination register. It is the initiator in front of the ALU and owns the register file, a host load port and a debug read port.

## Interface
- n, 32, datapath and register width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high exactly when state is IDLE
- instr  in  12  [11:9] op, [8:6] rd, [5:3] rs, [2:0] rt
- load_en  in  1  host register write request
- load_addr  in  3  host write index
- load_data  in  n  host write data
- alu_a  out  n  operand to ALU input R2 (registered)
- alu_b  out  n  operand to ALU input R3 (registered)
- alu_op  out  3  opcode to ALU input ALUOp (registered)
- alu_result  in  n  ALU output R1
- result  out  n  last written-back value
- done  out  1  one-cycle pulse when an instruction retires
- err  out  1  one-cycle pulse, coincident with done, for illegal op
- busy  out  1  state is not IDLE
- dbg_addr  in  3  debug read index
- dbg_data  out  n  combinational read of regfile[dbg_addr]

## Operation
- States: IDLE -> OPER -> EXEC -> WB -> IDLE; no other transitions except reset.
- IDLE: instr_ready=1. On instr_valid high, latch instr into the instruction register and go to OPER. Without instr_valid, stay.
- OPER: alu_a <= regfile[rs], alu_b <= regfile[rt], alu_op <= op. Go to EXEC.
- EXEC: result register <= alu_result. Go to WB.
- WB: if op != 3'b111, regfile[rd] <= result and done=1, err=0. If op == 3'b111, no write, done=1, err=1, and result holds its previous value. Go to IDLE.
- Opcodes supplied to the ALU:
  - 000: pass rs.
  - 001: bitwise NOT of rs; rt is ignored.
  - 010: add.
  - 011: subtract.
  - 100: OR.
  - 101: AND.
  - 110: signed less-than, giving 1 or 0 zero-extended to n bits.
- Width rules: add and subtract wrap modulo 2^n. There are no carry or overflow outputs.
- Host load port:
  - load_en is honoured only in IDLE; it is silently ignored in any other state.
  - A load and an instruction accept in the same IDLE cycle both take effect. OPER reads the register file one cycle later, so it sees the loaded value.
  - A WB write and a load can never coincide, because loads are ignored outside IDLE.
- Register file: 8 x n, all entries writable, no hardwired zero. rd may equal rs or rt; the read happens in OPER, before the write.
- Reset (any time, including mid-instruction):
  - State returns to IDLE and all registers clear to 0.
  - No pending writeback occurs.
  - Reset values: instr_ready=1, busy=0, done=0, err=0, result=0, alu_a=0, alu_b=0, alu_op=000, dbg_data=0.

## Timing
- Accept at edge T, where instr_valid=instr_ready=1.
- alu_a, alu_b and alu_op are valid after edge T+1.
- result is captured at edge T+2.
- done/err are high in the cycle following edge T+2. They are decoded from state WB and are combinational from state only.
- The regfile write lands at edge T+3. dbg_data shows the new value after T+3.
- instr_ready returns high after edge T+3, giving a throughput of one instruction per 4 cycles.
- instr_valid held while busy is not accepted. The instruction is taken on the first IDLE edge, and the upstream source must hold instr stable until then.
- The ALU is purely combinational. alu_result must settle within one cycle of alu_a, alu_b and alu_op changing.

## Test plan
- ADD: load r2=5, r3=7; issue op=010 rd=1 rs=2 rt=3 -> done pulses 3 cycles after accept; result=12; dbg r1=12; instr_ready back high on the next cycle.
- SUB and signed SLT:
  - r2=5, r3=7, op=011 -> rd=0xFFFFFFFE.
  - r2=0xFFFFFFFF, r3=1, op=110 -> rd=1.
  - Swapped operands -> rd=0.
- NOT and rd==rs: r4=0, op=001 rd=4 rs=4 rt=7 -> r4=0xFFFFFFFF; r7 unchanged.
- Illegal op 111, rd=5 with r5=0x1234 -> done=1 and err=1 for one cycle; r5 stays 0x1234; result unchanged.
- Handshake and loads:
  - Hold instr_valid high across two back-to-back instructions -> accepts 4 cycles apart.
  - Pulse load_en to r6 during EXEC -> r6 unchanged.
  - Load r2 in the same cycle as accepting an instruction that reads r2 -> the new value is used.
- Reset mid-operation: assert rst asynchronously during EXEC of ADD rd=1 -> all outputs take their reset values immediately; r1 stays 0; busy=0; the next instruction runs normally.
